// File: rtl/packet_alloc_scheduler.sv
// Wormhole switch allocator: per-outport round-robin arbitration, head-to-tail
// outport locking and downstream credit tracking per outport/VC.
module packet_alloc_scheduler #(
    parameter int NUM_IN      = 4,
    parameter int NUM_OUT     = 4,
    parameter int NUM_VCS     = 2,
    parameter int BUFFER_SIZE = 8,
    localparam int IN_BITS    = $clog2(NUM_IN),
    localparam int OUT_BITS   = $clog2(NUM_OUT),
    localparam int VC_BITS    = $clog2(NUM_VCS),
    localparam int CRED_BITS  = $clog2(BUFFER_SIZE + 1)
) (
    input  logic                                  clk,
    input  logic                                  n_rst,
    input  logic [NUM_IN-1:0]                     req,
    input  logic [NUM_IN*OUT_BITS-1:0]            req_outport,
    input  logic [NUM_IN*VC_BITS-1:0]             req_vc,
    input  logic [NUM_IN-1:0]                     req_tail,
    input  logic [NUM_OUT*NUM_VCS-1:0]            credit_return,
    output logic [NUM_IN-1:0]                     grant,
    output logic [NUM_OUT*IN_BITS-1:0]            select,
    output logic [NUM_OUT-1:0]                    enable,
    output logic [NUM_OUT-1:0]                    busy,
    output logic [NUM_OUT*NUM_VCS*CRED_BITS-1:0]  credits,
    output logic                                  credit_err
);

    // Handshake: grant[i] is the pop strobe for buffer i; a flit moves in any
    // cycle where req[i] and grant[i] are both high, and enable[o] marks the
    // outport it crosses. There is no back-pressure beyond credits.
    typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_t;

    state_t               r_state   [NUM_OUT];
    logic [IN_BITS-1:0]   r_rr_ptr  [NUM_OUT];
    logic [IN_BITS-1:0]   r_owner   [NUM_OUT];
    logic [VC_BITS-1:0]   r_lock_vc [NUM_OUT];
    logic [CRED_BITS-1:0] r_credits [NUM_OUT][NUM_VCS];
    logic                 r_credit_err;

    logic [OUT_BITS-1:0]  w_port    [NUM_IN];
    logic [VC_BITS-1:0]   w_vc      [NUM_IN];
    logic [IN_BITS-1:0]   w_win     [NUM_OUT];
    logic [VC_BITS-1:0]   w_send_vc [NUM_OUT];
    logic [NUM_OUT-1:0]   w_send;
    logic [NUM_OUT-1:0]   w_misroute;
    logic [NUM_IN-1:0]    w_grant;
    logic [NUM_OUT*NUM_VCS-1:0] w_ovf;

    always_comb begin
        for (int i = 0; i < NUM_IN; i++) begin
            w_port[i] = req_outport[i*OUT_BITS +: OUT_BITS];
            w_vc[i]   = req_vc[i*VC_BITS +: VC_BITS];
        end
    end

    always_comb begin
        logic [IN_BITS-1:0] w_idx;
        logic [IN_BITS-1:0] w_own;
        w_send     = '0;
        w_misroute = '0;
        w_grant    = '0;
        w_idx      = '0;
        w_own      = '0;
        for (int o = 0; o < NUM_OUT; o++) begin
            w_win[o]     = '0;
            w_send_vc[o] = '0;
        end
        for (int o = 0; o < NUM_OUT; o++) begin
            if (r_state[o] == ST_IDLE) begin
                // First eligible input at or after the round-robin pointer wins.
                for (int k = 0; k < NUM_IN; k++) begin
                    w_idx = IN_BITS'((int'(r_rr_ptr[o]) + k) % NUM_IN);
                    if (!w_send[o] && req[w_idx] && (w_port[w_idx] == OUT_BITS'(o)) &&
                        (r_credits[o][w_vc[w_idx]] != '0)) begin
                        w_send[o]    = 1'b1;
                        w_win[o]     = w_idx;
                        w_send_vc[o] = w_vc[w_idx];
                    end
                end
            end else begin
                w_own        = r_owner[o];
                w_win[o]     = w_own;
                w_send_vc[o] = r_lock_vc[o];
                if (req[w_own]) begin
                    if (w_port[w_own] != OUT_BITS'(o)) begin
                        w_misroute[o] = 1'b1;
                    end else if (r_credits[o][r_lock_vc[o]] != '0) begin
                        w_send[o] = 1'b1;
                    end
                end
            end
            if (w_send[o]) begin
                w_grant[w_win[o]] = 1'b1;
            end
        end
    end

    always_comb begin
        w_ovf = '0;
        for (int o = 0; o < NUM_OUT; o++) begin
            for (int v = 0; v < NUM_VCS; v++) begin
                if (credit_return[o*NUM_VCS+v] &&
                    !(w_send[o] && (w_send_vc[o] == VC_BITS'(v))) &&
                    (r_credits[o][v] == CRED_BITS'(BUFFER_SIZE))) begin
                    w_ovf[o*NUM_VCS+v] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int o = 0; o < NUM_OUT; o++) begin
                r_state[o]   <= ST_IDLE;
                r_rr_ptr[o]  <= '0;
                r_owner[o]   <= '0;
                r_lock_vc[o] <= '0;
                for (int v = 0; v < NUM_VCS; v++) begin
                    r_credits[o][v] <= CRED_BITS'(BUFFER_SIZE);
                end
            end
            r_credit_err <= 1'b0;
        end else begin
            for (int o = 0; o < NUM_OUT; o++) begin
                case (r_state[o])
                    ST_IDLE: begin
                        if (w_send[o]) begin
                            if (req_tail[w_win[o]]) begin
                                r_rr_ptr[o] <= IN_BITS'((int'(w_win[o]) + 1) % NUM_IN);
                            end else begin
                                r_state[o]   <= ST_LOCKED;
                                r_owner[o]   <= w_win[o];
                                r_lock_vc[o] <= w_vc[w_win[o]];
                            end
                        end
                    end
                    ST_LOCKED: begin
                        if (w_send[o] && req_tail[r_owner[o]]) begin
                            r_state[o]  <= ST_IDLE;
                            r_rr_ptr[o] <= IN_BITS'((int'(r_owner[o]) + 1) % NUM_IN);
                        end
                    end
                    default: r_state[o] <= ST_IDLE;
                endcase
                // A send and a return in the same cycle cancel out.
                for (int v = 0; v < NUM_VCS; v++) begin
                    if (credit_return[o*NUM_VCS+v] &&
                        !(w_send[o] && (w_send_vc[o] == VC_BITS'(v)))) begin
                        if (r_credits[o][v] != CRED_BITS'(BUFFER_SIZE)) begin
                            r_credits[o][v] <= r_credits[o][v] + 1'b1;
                        end
                    end else if (!credit_return[o*NUM_VCS+v] &&
                                 w_send[o] && (w_send_vc[o] == VC_BITS'(v))) begin
                        r_credits[o][v] <= r_credits[o][v] - 1'b1;
                    end
                end
            end
            r_credit_err <= r_credit_err | (|w_misroute) | (|w_ovf);
        end
    end

    always_comb begin
        grant  = w_grant;
        enable = w_send;
        for (int o = 0; o < NUM_OUT; o++) begin
            busy[o]                          = (r_state[o] == ST_LOCKED);
            select[o*IN_BITS +: IN_BITS]     = w_win[o];
            for (int v = 0; v < NUM_VCS; v++) begin
                credits[(o*NUM_VCS+v)*CRED_BITS +: CRED_BITS] = r_credits[o][v];
            end
        end
    end

    assign credit_err = r_credit_err;

endmodule
